// File: rtl/ram.sv
// Multi-cycle single-port word memory for the load/store unit: one request at a
// time, fixed-latency completion with a one-cycle read or write status pulse.
module ram #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        nRD,
  input  logic        nWR,
  output logic [31:0] Dataout,
  output logic        readStatus,
  output logic        writeStatus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  is_rd_q, is_rd_d;
  logic [31:0]           dout_q, dout_d;
  logic                  rd_st_q, rd_st_d;
  logic                  wr_st_q, wr_st_d;

  // Storage powers up cleared and is deliberately outside the reset domain.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic        done;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        unused_addr;

  // Byte offset and bits above the word index are ignored, so addresses alias.
  assign unused_addr = ^{address[31:DEPTH_LOG2+2], address[1:0]};

  assign mem_rdata = mem[idx_q];
  assign done      = (state_q == BUSY) && (cnt_q == CNT_ONE);
  assign mem_we    = done && !is_rd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_rd_d = is_rd_q;
    dout_d  = dout_q;
    rd_st_d = 1'b0;
    wr_st_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A read wins when both strobes are low together.
        if (!nRD || !nWR) begin
          state_d = BUSY;
          cnt_d   = LAT_INIT;
          idx_d   = address[DEPTH_LOG2+1:2];
          wdata_d = writeData;
          is_rd_d = !nRD;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          if (is_rd_q) begin
            dout_d  = mem_rdata;
            rd_st_d = 1'b1;
          end else begin
            wr_st_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      is_rd_q <= 1'b0;
      dout_q  <= '0;
      rd_st_q <= 1'b0;
      wr_st_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_rd_q <= is_rd_d;
      dout_q  <= dout_d;
      rd_st_q <= rd_st_d;
      wr_st_q <= wr_st_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign Dataout     = dout_q;
  assign readStatus  = rd_st_q;
  assign writeStatus = wr_st_q;

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: a vector table on a LATENCY=3 instance, plus
// hand sequences for busy-ignore, reset abort and LATENCY=1/5 back-to-back.
module tb_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [31:0] dout_s  [3];
  logic        nrd_s   [3];
  logic        nwr_s   [3];
  logic        rst_s   [3];
  logic        wst_s   [3];

  int n_checks = 0;
  int n_errors = 0;

  ram #(.DEPTH_LOG2(8), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .address(addr_s[0]), .writeData(wdata_s[0]),
    .nRD(nrd_s[0]), .nWR(nwr_s[0]), .Dataout(dout_s[0]),
    .readStatus(rst_s[0]), .writeStatus(wst_s[0])
  );

  ram #(.DEPTH_LOG2(8), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .address(addr_s[1]), .writeData(wdata_s[1]),
    .nRD(nrd_s[1]), .nWR(nwr_s[1]), .Dataout(dout_s[1]),
    .readStatus(rst_s[1]), .writeStatus(wst_s[1])
  );

  ram #(.DEPTH_LOG2(8), .LATENCY(5)) u_l5 (
    .clk(clk), .rst_n(rst_n), .address(addr_s[2]), .writeData(wdata_s[2]),
    .nRD(nrd_s[2]), .nWR(nwr_s[2]), .Dataout(dout_s[2]),
    .readStatus(rst_s[2]), .writeStatus(wst_s[2])
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_dout;
    string       name;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] data,
                              logic exp_rd, logic exp_wr, logic [31:0] exp_dout, string name);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.data = data;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_dout = exp_dout; v.name = name;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Strobes are set now, sampled on the next edge (E0), released 1ns after it.
  task automatic start_req(int idx, logic rd, logic wr, logic [31:0] addr, logic [31:0] data);
    addr_s[idx]  = addr;
    wdata_s[idx] = data;
    nrd_s[idx]   = ~rd;
    nwr_s[idx]   = ~wr;
    @(posedge clk);
    #1;
    nrd_s[idx]   = 1'b1;
    nwr_s[idx]   = 1'b1;
    addr_s[idx]  = ~addr;
    wdata_s[idx] = ~data;
  endtask

  task automatic watch(int idx, logic exp_rd, logic exp_wr, string name);
    @(posedge clk);
    #1;
    chk(name, {30'd0, rst_s[idx], wst_s[idx]}, {30'd0, exp_rd, exp_wr});
  endtask

  task automatic access(int idx, int lat, logic rd, logic wr, logic [31:0] addr,
                        logic [31:0] data, logic exp_rd, logic exp_wr,
                        logic [31:0] exp_dout, string name);
    start_req(idx, rd, wr, addr, data);
    for (int c = 1; c <= lat + 2; c++) begin
      watch(idx, exp_rd && (c == lat), exp_wr && (c == lat), {name, "_status"});
      if (c >= lat) chk({name, "_dout"}, dout_s[idx], exp_dout);
    end
  endtask

  // Each new request is issued so that it is sampled at E0+LATENCY+1.
  task automatic b2b(int idx, int lat, logic [31:0] base, logic [31:0] da, logic [31:0] db);
    start_req(idx, 1'b0, 1'b1, base, da);
    for (int c = 1; c < lat; c++) watch(idx, 1'b0, 1'b0, "b2b_w1_wait");
    watch(idx, 1'b0, 1'b1, "b2b_w1_done");
    start_req(idx, 1'b0, 1'b1, base + 32'd4, db);
    chk("b2b_w1_drop", {31'd0, wst_s[idx]}, 32'd0);
    for (int c = 1; c < lat; c++) watch(idx, 1'b0, 1'b0, "b2b_w2_wait");
    watch(idx, 1'b0, 1'b1, "b2b_w2_done");
    start_req(idx, 1'b1, 1'b0, base, 32'd0);
    chk("b2b_w2_drop", {31'd0, wst_s[idx]}, 32'd0);
    for (int c = 1; c < lat; c++) watch(idx, 1'b0, 1'b0, "b2b_r1_wait");
    watch(idx, 1'b1, 1'b0, "b2b_r1_done");
    chk("b2b_r1_dout", dout_s[idx], da);
    start_req(idx, 1'b1, 1'b0, base + 32'd4, 32'd0);
    chk("b2b_r1_drop", {31'd0, rst_s[idx]}, 32'd0);
    for (int c = 1; c < lat; c++) watch(idx, 1'b0, 1'b0, "b2b_r2_wait");
    watch(idx, 1'b1, 1'b0, "b2b_r2_done");
    chk("b2b_r2_dout", dout_s[idx], db);
    watch(idx, 1'b0, 1'b0, "b2b_r2_drop");
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_s[i] = '0; wdata_s[i] = '0; nrd_s[i] = 1'b1; nwr_s[i] = 1'b1;
    end

    vecs[0]  = mk(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 32'h0000_0000, "v0_wr_10");
    vecs[1]  = mk(1, 0, 32'h0000_0010, 32'h0,         1, 0, 32'hDEAD_BEEF, "v1_rd_10");
    vecs[2]  = mk(0, 1, 32'h0000_0004, 32'h1234_5678, 0, 1, 32'hDEAD_BEEF, "v2_wr_04");
    vecs[3]  = mk(1, 0, 32'h0000_0405, 32'h0,         1, 0, 32'h1234_5678, "v3_rd_alias405");
    vecs[4]  = mk(1, 0, 32'h0000_0020, 32'h0,         1, 0, 32'h0000_0000, "v4_rd_fresh20");
    vecs[5]  = mk(0, 1, 32'hFFFF_FC0C, 32'hCAFE_F00D, 0, 1, 32'h0000_0000, "v5_wr_hiC");
    vecs[6]  = mk(1, 0, 32'h0000_000C, 32'h0,         1, 0, 32'hCAFE_F00D, "v6_rd_0C");
    vecs[7]  = mk(1, 0, 32'h0000_0013, 32'h0,         1, 0, 32'hDEAD_BEEF, "v7_rd_byteoff13");
    vecs[8]  = mk(1, 1, 32'h0000_0010, 32'h0000_0055, 1, 0, 32'hDEAD_BEEF, "v8_both_strobes");
    vecs[9]  = mk(1, 0, 32'h0000_0004, 32'h0,         1, 0, 32'h1234_5678, "v9_rd_04");
    vecs[10] = mk(1, 0, 32'h0000_0010, 32'h0,         1, 0, 32'hDEAD_BEEF, "v10_rd_10_kept");
    vecs[11] = mk(0, 1, 32'h0000_0008, 32'h0000_0011, 0, 1, 32'hDEAD_BEEF, "v11_wr_08");

    // Reset state on every instance.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_dout", dout_s[i], 32'd0);
      chk("reset_rdst", {31'd0, rst_s[i]}, 32'd0);
      chk("reset_wrst", {31'd0, wst_s[i]}, 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      access(0, 3, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
             vecs[i].exp_rd, vecs[i].exp_wr, vecs[i].exp_dout, vecs[i].name);
    end

    // Write strobe during BUSY is dropped.
    start_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    addr_s[0] = 32'h0000_0010; wdata_s[0] = 32'h0000_0001; nwr_s[0] = 1'b0;
    watch(0, 1'b0, 1'b0, "busy_c1");
    nwr_s[0] = 1'b1;
    watch(0, 1'b0, 1'b0, "busy_c2");
    watch(0, 1'b1, 1'b0, "busy_c3");
    watch(0, 1'b0, 1'b0, "busy_c4");
    watch(0, 1'b0, 1'b0, "busy_c5");
    access(0, 3, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 1'b0, 32'h1234_5678, "busy_rd04");
    access(0, 3, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, "busy_rd10");

    // Reset one cycle into a write aborts it.
    start_req(0, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_00AA);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_dout", dout_s[0], 32'd0);
    chk("rstmid_wrst", {31'd0, wst_s[0]}, 32'd0);
    watch(0, 1'b0, 1'b0, "rstmid_c2");
    watch(0, 1'b0, 1'b0, "rstmid_c3");
    rst_n = 1'b1;
    watch(0, 1'b0, 1'b0, "rstmid_c4");
    watch(0, 1'b0, 1'b0, "rstmid_c5");
    access(0, 3, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1, 1'b0, 32'h0000_0011, "rstmid_rd08");

    // LATENCY=1: basic access and a strobe on the completion edge is ignored.
    access(1, 1, 1'b0, 1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0, "l1_wr30");
    access(1, 1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b1, 1'b0, 32'hA5A5_A5A5, "l1_rd30");
    start_req(1, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
    addr_s[1] = 32'h0000_0030; wdata_s[1] = 32'h0000_000F; nwr_s[1] = 1'b0;
    watch(1, 1'b1, 1'b0, "l1_edge_c1");
    nwr_s[1] = 1'b1;
    watch(1, 1'b0, 1'b0, "l1_edge_c2");
    watch(1, 1'b0, 1'b0, "l1_edge_c3");
    access(1, 1, 1'b1, 1'b0, 32'h0000_0034, 32'h0, 1'b1, 1'b0, 32'h0, "l1_rd34");
    access(1, 1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b1, 1'b0, 32'hA5A5_A5A5, "l1_rd30_kept");
    b2b(1, 1, 32'h0000_0100, 32'h1111_0001, 32'h2222_0002);

    // LATENCY=5.
    access(2, 5, 1'b0, 1'b1, 32'h0000_0040, 32'h5A5A_0F0F, 1'b0, 1'b1, 32'h0, "l5_wr40");
    access(2, 5, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 32'h5A5A_0F0F, "l5_rd40");
    b2b(2, 5, 32'h0000_0200, 32'h3333_0003, 32'h4444_0004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
